// File: rtl/path_sequencer.sv
// Walks the solved node list and issues one hop at a time to the motion unit.
// Build option: define PATH_REVERSE_EN when the buffer holds the path destination-first.
//
// state      | meaning
// IDLE       | waiting for start, buffer writable
// SCAN       | measuring path length, one entry per cycle
// ISSUE      | cmd_valid high, waiting for cmd_ready
// WAIT_ARR   | command accepted, waiting for arrival or timeout
// DONE       | path completed, done held until next start
// ERR        | timeout or malformed path, error held until next start
module path_sequencer #(
    parameter int NODE_W  = 14,
    parameter int DEPTH   = 37,
    parameter int TERM    = 37,
    parameter int TIMEOUT = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [5:0]        wr_idx,
    input  logic [NODE_W-1:0] wr_node,
    input  logic              start,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [NODE_W-1:0] cmd_node,
    output logic [5:0]        cmd_hop,
    input  logic              arrived,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [5:0]        hops_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_ISSUE, S_WAIT_ARR, S_DONE, S_ERR
    } state_t;

    localparam logic [NODE_W-1:0] TERM_V    = NODE_W'(TERM);
    localparam logic [5:0]        DEPTH_V   = 6'(DEPTH);
    localparam logic [31:0]       TIMEOUT_V = 32'(TIMEOUT);

    state_t            state;
    logic [5:0]        idx;
    logic [5:0]        ptr;
    logic [5:0]        len;
    logic [31:0]       timer;
    logic [NODE_W-1:0] path_buf [DEPTH];

    logic [NODE_W-1:0] scan_word;
    logic              writable;
    logic [5:0]        first_slot;
    logic [5:0]        next_slot;

    always_comb begin
        scan_word = TERM_V;
        if (idx < DEPTH_V)
            scan_word = path_buf[idx];
        writable = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
`ifdef PATH_REVERSE_EN
        // Hop n lives at slot L-1-n; in SCAN the length is still in idx.
        first_slot = idx - 6'd2;
        next_slot  = len - ptr - 6'd2;
`else
        first_slot = 6'd1;
        next_slot  = ptr + 6'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            ptr       <= '0;
            len       <= '0;
            timer     <= '0;
            cmd_valid <= 1'b0;
            cmd_node  <= '0;
            cmd_hop   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            hops_done <= '0;
            for (int i = 0; i < DEPTH; i++)
                path_buf[i] <= TERM_V;
        end else begin
            if (wr_en && writable && (wr_idx < DEPTH_V))
                path_buf[wr_idx] <= wr_node;

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state     <= S_SCAN;
                        idx       <= '0;
                        hops_done <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if ((idx == DEPTH_V) || (scan_word == TERM_V)) begin
                        len <= idx;
                        if (idx < 6'd2) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= S_ISSUE;
                            ptr       <= 6'd1;
                            cmd_valid <= 1'b1;
                            cmd_node  <= path_buf[first_slot];
                            cmd_hop   <= 6'd1;
                        end
                    end else if (scan_word > TERM_V) begin
                        state <= S_ERR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        state     <= S_WAIT_ARR;
                        cmd_valid <= 1'b0;
                        timer     <= '0;
                    end
                end
                S_WAIT_ARR: begin
                    // Arrival is checked first so it wins over a same-cycle timeout.
                    if (arrived) begin
                        hops_done <= hops_done + 6'd1;
                        ptr       <= ptr + 6'd1;
                        if (ptr == len - 6'd1) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= S_ISSUE;
                            cmd_valid <= 1'b1;
                            cmd_node  <= path_buf[next_slot];
                            cmd_hop   <= ptr + 6'd1;
                        end
                    end else if (timer == TIMEOUT_V - 32'd1) begin
                        state <= S_ERR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else if (timer < TIMEOUT_V) begin
                        timer <= timer + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_path_sequencer.sv
// Randomized bench for path_sequencer; expectations come from a list-level model of the path.
// Build with PATH_REVERSE_EN defined to exercise destination-first ordering.
module tb_path_sequencer;

    localparam int NODE_W  = 14;
    localparam int DEPTH   = 37;
    localparam int TERM    = 37;
    localparam int TIMEOUT = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [5:0]        wr_idx = '0;
    logic [NODE_W-1:0] wr_node = '0;
    logic              start = 1'b0;
    logic              cmd_valid;
    logic              cmd_ready = 1'b0;
    logic [NODE_W-1:0] cmd_node;
    logic [5:0]        cmd_hop;
    logic              arrived = 1'b0;
    logic              busy;
    logic              done;
    logic              error;
    logic [5:0]        hops_done;

    path_sequencer #(
        .NODE_W(NODE_W), .DEPTH(DEPTH), .TERM(TERM), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_node(wr_node),
        .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_node(cmd_node), .cmd_hop(cmd_hop), .arrived(arrived), .busy(busy),
        .done(done), .error(error), .hops_done(hops_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int mdl [DEPTH];

    // Modes: 0 normal, 1 timeout on hop 1, 2 reset during WAIT_ARR,
    // 3 arrival on the timeout cycle, 4 write attempted during WAIT_ARR.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_model();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_idx = 6'(i); wr_node = NODE_W'(mdl[i]);
            tick();
        end
        wr_idx = 6'd40; wr_node = 14'd50;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) mdl[i] = TERM;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, 32'(cmd_valid), 0);
        check_val({tag, "_node"},  32'(cmd_node), 0);
        check_val({tag, "_hop"},   32'(cmd_hop), 0);
        check_val({tag, "_busy"},  32'(busy), 0);
        check_val({tag, "_done"},  32'(done), 0);
        check_val({tag, "_error"}, 32'(error), 0);
        check_val({tag, "_hops"},  32'(hops_done), 0);
    endtask

    task automatic run_path(input int mode, input int stall_fix, input bit do_load);
        int k, n, d, stall, plen;
        bit bad;
        int exp_q[$];

        k = DEPTH;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (mdl[i] >= TERM) k = i;
        bad  = (k < DEPTH) && (mdl[k] > TERM);
        plen = k;
        if (!bad && plen >= 2) begin
`ifdef PATH_REVERSE_EN
            for (int i = plen - 2; i >= 0; i--) exp_q.push_back(mdl[i]);
`else
            for (int i = 1; i < plen; i++) exp_q.push_back(mdl[i]);
`endif
        end

        if (do_load) load_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("start_busy",  32'(busy), 1);
        check_val("start_error", 32'(error), 0);
        check_val("start_done",  32'(done), 0);
        check_val("start_hops",  32'(hops_done), 0);

        n = 0;
        while (!cmd_valid && !done && !error && n < 200) begin
            tick();
            n++;
        end
        check_val("scan_latency", 32'(n), 32'(k + 1));

        if (bad) begin
            check_val("bad_error", 32'(error), 1);
            check_val("bad_valid", 32'(cmd_valid), 0);
            check_val("bad_done",  32'(done), 0);
            return;
        end
        if (exp_q.size() == 0) begin
            check_val("short_done",  32'(done), 1);
            check_val("short_valid", 32'(cmd_valid), 0);
            check_val("short_busy",  32'(busy), 0);
            check_val("short_hops",  32'(hops_done), 0);
            return;
        end

        for (int h = 1; h <= exp_q.size(); h++) begin
            check_val("cmd_valid", 32'(cmd_valid), 1);
            check_val("cmd_node",  32'(cmd_node), 32'(exp_q[h-1]));
            check_val("cmd_hop",   32'(cmd_hop), 32'(h));

            stall = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) begin
                arrived = (s == 0);
                start   = (s == 0);
                tick();
                arrived = 1'b0;
                start   = 1'b0;
                check_val("stall_valid", 32'(cmd_valid), 1);
                check_val("stall_node",  32'(cmd_node), 32'(exp_q[h-1]));
                check_val("stall_hop",   32'(cmd_hop), 32'(h));
                check_val("stall_hops",  32'(hops_done), 32'(h - 1));
            end

            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
            check_val("hs_valid", 32'(cmd_valid), 0);
            check_val("hs_busy",  32'(busy), 1);

            if (mode == 1 && h == 1) begin
                n = 0;
                while (!error && n < 100) begin
                    tick();
                    n++;
                end
                check_val("timeout_latency", 32'(n), 32'(TIMEOUT));
                check_val("timeout_error", 32'(error), 1);
                check_val("timeout_done",  32'(done), 0);
                check_val("timeout_hops",  32'(hops_done), 0);
                check_val("timeout_busy",  32'(busy), 0);
                return;
            end
            if (mode == 2 && h == 1) begin
                tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_reset_outputs("midwalk_rst");
                clear_model();
                return;
            end

            if (mode == 3 && h == 1) d = TIMEOUT - 1;
            else if (mode == 4)      d = int'($urandom_range(1, 5));
            else                     d = int'($urandom_range(0, 5));
            for (int s = 0; s < d; s++) begin
                if (mode == 4 && s == 0 && h < exp_q.size()) begin
                    wr_en = 1'b1;
`ifdef PATH_REVERSE_EN
                    wr_idx = 6'(plen - 2 - h);
`else
                    wr_idx = 6'(h + 1);
`endif
                    wr_node = NODE_W'((exp_q[h] + 1) % TERM);
                end
                tick();
                wr_en = 1'b0;
            end
            arrived = 1'b1;
            tick();
            arrived = 1'b0;
            check_val("arr_hops", 32'(hops_done), 32'(h));
            if (h == exp_q.size()) begin
                check_val("end_done",  32'(done), 1);
                check_val("end_busy",  32'(busy), 0);
                check_val("end_valid", 32'(cmd_valid), 0);
                check_val("end_error", 32'(error), 0);
            end
        end
    endtask

    task automatic set_directed();
        clear_model();
`ifdef PATH_REVERSE_EN
        mdl[0] = 21; mdl[1] = 28; mdl[2] = 31; mdl[3] = 33;
`else
        mdl[0] = 33; mdl[1] = 31; mdl[2] = 28; mdl[3] = 21;
`endif
    endtask

    initial begin
        int plen;
        clear_model();
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        run_path(0, 0, 1'b0);

        set_directed(); run_path(0, 0, 1'b1);
        set_directed(); run_path(0, 10, 1'b1);
        set_directed(); run_path(1, 0, 1'b1);
        run_path(0, 1, 1'b0);

        clear_model(); mdl[0] = 36; run_path(0, 0, 1'b1);
        clear_model(); mdl[0] = 33; mdl[1] = 31; mdl[2] = 50; mdl[3] = 21;
        run_path(0, 0, 1'b1);

        set_directed(); run_path(4, 0, 1'b1);
        set_directed(); run_path(3, 0, 1'b1);
        set_directed(); run_path(2, 0, 1'b1);
        run_path(0, 0, 1'b0);

        for (int i = 0; i < DEPTH; i++) mdl[i] = int'($urandom_range(0, TERM - 1));
        run_path(0, -1, 1'b1);

        for (int t = 0; t < 25; t++) begin
            plen = int'($urandom_range(0, 9));
            for (int i = 0; i < DEPTH; i++) begin
                if (i < plen)       mdl[i] = int'($urandom_range(0, TERM - 1));
                else if (i == plen) mdl[i] = TERM;
                else                mdl[i] = int'($urandom_range(0, 16383));
            end
            if (plen > 0 && $urandom_range(0, 4) == 0)
                mdl[$urandom_range(0, plen - 1)] = int'($urandom_range(TERM + 1, 16383));
            run_path(($urandom_range(0, 3) == 0) ? 4 : 0, -1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/path_sequencer.md
Name: path_sequencer

Overview:
- Sits directly downstream of the shortest-path solver.
- Holds the solved node list: 14-bit node IDs, index 0 = start node, value 37 = end-of-path terminator.
- Walks the list one hop at a time. Each next node goes to the motion/line-follow unit over a valid/ready handshake, then the block waits for an arrival pulse before issuing the next hop.
- Reports completion, hop progress, and timeout/format errors to the top-level controller.

Parameters:
- NODE_W, 14, node ID width (matches solver output width).
- DEPTH, 37, path buffer entries (graph node count).
- TERM, 37, terminator / empty-slot value.
- TIMEOUT, 50000000, maximum cycles to wait for arrival per hop.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  path buffer write strobe.
- wr_idx  in  6  write index, 0..DEPTH-1; writes with wr_idx >= DEPTH are ignored.
- wr_node  in  NODE_W  node ID to write.
- start  in  1  begin walking the stored path (level or pulse; sampled per cycle).
- cmd_valid  out  1  next-node command valid.
- cmd_ready  in  1  motion unit accepts command.
- cmd_node  out  NODE_W  target node of the current hop.
- cmd_hop  out  6  hop number of the current command, 1-based.
- arrived  in  1  one-cycle pulse: robot reached the commanded node.
- busy  out  1  high in SCAN/ISSUE/WAIT_ARR.
- done  out  1  path completed.
- error  out  1  timeout or malformed path.
- hops_done  out  6  hops completed since the last start.

Behaviour:
- Reset: all buffer entries = TERM; state IDLE; cmd_valid=0, cmd_node=0, cmd_hop=0, busy=0, done=0, error=0, hops_done=0, timer=0.
  - Reset mid-walk aborts immediately with the same values; there is no partial retention.
- Writes: accepted only in IDLE, DONE or ERR; ignored while busy. A write is visible to a start sampled on the following edge or later.
- States: IDLE, SCAN, ISSUE, WAIT_ARR, DONE, ERR.
- IDLE/DONE/ERR, start=1: go to SCAN with idx=0, hops_done=0, done=0, error=0.
- SCAN: examines buf[idx], one entry per cycle.
  - buf[idx]==TERM, or idx==DEPTH: length L=idx.
  - buf[idx]>TERM: go to ERR.
  - Otherwise: idx++.
  - On finding L: if L<2, go to DONE (zero hops; robot is already at the destination). Else ptr=1 and go to ISSUE.
  - Latency: cmd_valid first goes high L+1 cycles after the start edge.
- ISSUE:
  - cmd_valid=1, cmd_node=buf[ptr], cmd_hop=ptr.
  - cmd_node and cmd_hop are held stable until cmd_valid&&cmd_ready.
  - On handshake: cmd_valid drops the next cycle, timer=0, go to WAIT_ARR.
- WAIT_ARR: timer++ each cycle.
  - arrived=1: hops_done++ and ptr++. If ptr==L-1, go to DONE; else go to ISSUE (cmd_valid high the next cycle).
  - timer==TIMEOUT-1 without arrived: go to ERR.
  - arrived and timeout in the same cycle: arrival wins.
- arrived outside WAIT_ARR is ignored.
- start while busy is ignored.
- DONE and ERR hold their flag (done or error) until the next start or rst. Outputs hops_done and cmd_node keep their last values.
- Arithmetic: idx, ptr and hops_done are 6-bit unsigned and never exceed DEPTH. The timer is 32-bit and saturates at TIMEOUT.

Optional Feature:
- PATH_REVERSE_EN defined:
  - The buffer holds the path destination-first (backtrace order), with index L-1 = start node.
  - SCAN is unchanged.
  - Issue order is buf[L-2] down to buf[0].
  - cmd_hop still counts 1..L-1, and completion is reached after L-1 arrivals.
- PATH_REVERSE_EN undefined: forward order as described above.

Test Plan:
- Write path 33,31,28,21,37; pulse start:
  - cmd_valid rises 5 cycles after start with cmd_node=31, cmd_hop=1.
  - With cmd_ready tied 1 and an arrived pulse 3 cycles after each handshake, the bench sees 31, 28, 21 in order.
  - Final state: done=1, hops_done=3, busy=0.
- Hold cmd_ready=0 for 10 cycles during hop 2:
  - cmd_valid stays 1 with cmd_node=28, cmd_hop=2 stable.
  - An arrived pulse during ISSUE does not change hops_done.
- Set TIMEOUT=20; never pulse arrived after the first handshake:
  - error=1 exactly 20 cycles after the handshake; done=0, hops_done=0.
  - A fresh start clears error and reissues hop 1.
- Buffer with only entry 0=36 (rest TERM): start gives done=1 after 2 cycles, cmd_valid never asserted.
- Entry 2=50: start gives error=1 in SCAN with no command issued. Also: wr_en during WAIT_ARR leaves the buffer unchanged; rst in WAIT_ARR returns all outputs to their reset values on the next edge.
- PATH_REVERSE_EN build, buffer 21,28,31,33,37: commands issue 31, 28, 21, then done=1, hops_done=3.
